// File: rtl/cpu_pkg.sv
// Shared constants for the CPU control path: opcodes, ALU select codes, run-control states
// and the decoded-control bundle passed from the decoder to the run-control logic.
package cpu_pkg;

  localparam int unsigned StackDepthDefault = 8;

  localparam logic [4:0] OpLdm  = 5'b10100;
  localparam logic [4:0] OpStm  = 5'b10101;
  localparam logic [4:0] OpBz   = 5'b10110;
  localparam logic [4:0] OpBnz  = 5'b10111;
  localparam logic [4:0] OpBc   = 5'b11000;
  localparam logic [4:0] OpBnc  = 5'b11001;
  localparam logic [4:0] OpJmp  = 5'b11010;
  localparam logic [4:0] OpJsb  = 5'b11011;
  localparam logic [4:0] OpRet  = 5'b11100;
  localparam logic [4:0] OpHalt = 5'b11101;
  localparam logic [4:0] OpIll0 = 5'b11110;
  localparam logic [4:0] OpIll1 = 5'b11111;

  localparam logic [3:0] AluPass     = 4'b0000;
  localparam logic       AluArithGrp = 1'b0;
  localparam logic [1:0] AluShiftGrp = 2'b10;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StHalted = 2'd1,
    StFault  = 2'd2
  } state_e;

  typedef struct packed {
    logic       push;
    logic       pop;
    logic       mem_we;
    logic       reg_we;
    logic       imm_mem;
    logic       stm;
    logic       ldm;
    logic       branch;
    logic       jmp;
    logic       jsb;
    logic [3:0] alu_op;
    logic       halt;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Purely combinational opcode decode; run-control gating is applied by the caller.
module ctrl_decoder
  import cpu_pkg::*;
(
  input  logic [4:0] opcode_i,
  input  logic       cout_i,
  input  logic       zout_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique casez (opcode_i)
      5'b00???: begin
        ctrl_o.reg_we = 1'b1;
        ctrl_o.alu_op = {AluArithGrp, opcode_i[2:0]};
      end
      5'b01???: begin
        ctrl_o.reg_we  = 1'b1;
        ctrl_o.imm_mem = 1'b1;
        ctrl_o.alu_op  = {AluArithGrp, opcode_i[2:0]};
      end
      5'b100??: begin
        ctrl_o.reg_we = 1'b1;
        ctrl_o.alu_op = {AluShiftGrp, opcode_i[1:0]};
      end
      OpLdm: begin
        ctrl_o.imm_mem = 1'b1;
        ctrl_o.ldm     = 1'b1;
        ctrl_o.reg_we  = 1'b1;
        ctrl_o.alu_op  = AluPass;
      end
      OpStm: begin
        ctrl_o.imm_mem = 1'b1;
        ctrl_o.stm     = 1'b1;
        ctrl_o.mem_we  = 1'b1;
        ctrl_o.alu_op  = AluPass;
      end
      OpBz:   ctrl_o.branch = zout_i;
      OpBnz:  ctrl_o.branch = ~zout_i;
      OpBc:   ctrl_o.branch = cout_i;
      OpBnc:  ctrl_o.branch = ~cout_i;
      OpJmp:  ctrl_o.jmp = 1'b1;
      OpJsb: begin
        ctrl_o.jmp  = 1'b1;
        ctrl_o.push = 1'b1;
      end
      OpRet: begin
        ctrl_o.pop = 1'b1;
        ctrl_o.jsb = 1'b1;
      end
      OpHalt:         ctrl_o.halt = 1'b1;
      OpIll0, OpIll1: ctrl_o.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Run-control wrapper: gates decoded controls by RUN/HALTED/FAULT state, tracks the
// return-stack depth and counts retired instructions.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = StackDepthDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  opcodeFunc,
  input  logic        Cout,
  input  logic        Zout,
  input  logic        step,
  input  logic        resume,
  output logic        push,
  output logic        pop,
  output logic        memWriteEn,
  output logic        regWriteEn,
  output logic        immAndmem,
  output logic        stm,
  output logic        ldm,
  output logic        branch,
  output logic        jmp,
  output logic        jsb,
  output logic [3:0]  aluOp,
  output logic        pcHold,
  output logic        halted,
  output logic        fault,
  output logic        illegal,
  output logic [15:0] retired
);

  localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);

  state_e            state_q;
  logic [DepthW-1:0] depth_q;
  logic [15:0]       retired_q;
  ctrl_t             dec;
  ctrl_t             ctl;
  logic              exec, stack_err, do_fault, do_retire;

  ctrl_decoder u_dec (
    .opcode_i (opcodeFunc),
    .cout_i   (Cout),
    .zout_i   (Zout),
    .ctrl_o   (dec)
  );

  always_comb begin
    // A step in HALTED only executes when resume is not also requested.
    exec      = (state_q == StRun) || (state_q == StHalted && step && !resume);
    stack_err = (dec.push && depth_q == DepthW'(STACK_DEPTH)) ||
                (dec.pop && depth_q == '0);
    do_fault  = !rst && exec && stack_err;
    do_retire = !rst && exec && !stack_err && !dec.halt;
    ctl       = do_retire ? dec : '0;
  end

  assign push       = ctl.push;
  assign pop        = ctl.pop;
  assign memWriteEn = ctl.mem_we;
  assign regWriteEn = ctl.reg_we;
  assign immAndmem  = ctl.imm_mem;
  assign stm        = ctl.stm;
  assign ldm        = ctl.ldm;
  assign branch     = ctl.branch;
  assign jmp        = ctl.jmp;
  assign jsb        = ctl.jsb;
  assign aluOp      = ctl.alu_op;
  assign illegal    = ctl.illegal;
  assign pcHold     = !do_retire;
  assign halted     = !rst && state_q == StHalted;
  assign fault      = !rst && state_q == StFault;
  assign retired    = retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      depth_q   <= '0;
      retired_q <= '0;
    end else begin
      if (do_retire) begin
        retired_q <= retired_q + 16'd1;
        if (dec.push) depth_q <= depth_q + DepthW'(1);
        else if (dec.pop) depth_q <= depth_q - DepthW'(1);
      end
      unique case (state_q)
        StRun: begin
          if (do_fault) state_q <= StFault;
          else if (dec.halt) state_q <= StHalted;
        end
        StHalted: begin
          if (resume) state_q <= StRun;
          else if (do_fault) state_q <= StFault;
        end
        StFault: state_q <= StFault;
        default: state_q <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: stimulus queues expected outputs, a negedge monitor
// pops and compares them.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst, Cout, Zout, step, resume;
  logic [4:0]  opcodeFunc;
  logic        push, pop, memWriteEn, regWriteEn, immAndmem, stm, ldm, branch, jmp, jsb;
  logic [3:0]  aluOp;
  logic        pcHold, halted, fault, illegal;
  logic [15:0] retired;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [17:0] vec;
    logic [15:0] ret;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  cpu_controller #(.STACK_DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcodeFunc (opcodeFunc),
    .Cout       (Cout),
    .Zout       (Zout),
    .step       (step),
    .resume     (resume),
    .push       (push),
    .pop        (pop),
    .memWriteEn (memWriteEn),
    .regWriteEn (regWriteEn),
    .immAndmem  (immAndmem),
    .stm        (stm),
    .ldm        (ldm),
    .branch     (branch),
    .jmp        (jmp),
    .jsb        (jsb),
    .aluOp      (aluOp),
    .pcHold     (pcHold),
    .halted     (halted),
    .fault      (fault),
    .illegal    (illegal),
    .retired    (retired)
  );

  // {push,pop,memWe,regWe,imm,stm,ldm,branch,jmp,jsb,aluOp,pcHold,halted,fault,illegal}
  logic [17:0] act_vec;
  assign act_vec = {push, pop, memWriteEn, regWriteEn, immAndmem, stm, ldm, branch, jmp, jsb,
                    aluOp, pcHold, halted, fault, illegal};

  localparam logic [17:0] VReset   = 18'h00008;
  localparam logic [17:0] VHold    = 18'h00008;
  localparam logic [17:0] VHalted  = 18'h0000C;
  localparam logic [17:0] VFault   = 18'h0000A;
  localparam logic [17:0] VImm2    = 18'h06020;
  localparam logic [17:0] VBrOff   = 18'h00000;
  localparam logic [17:0] VBrOn    = 18'h00400;
  localparam logic [17:0] VStmStep = 18'h0B004;
  localparam logic [17:0] VStmRun  = 18'h0B000;
  localparam logic [17:0] VIllegal = 18'h00001;
  localparam logic [17:0] VJsb     = 18'h20200;
  localparam logic [17:0] VRet     = 18'h10100;
  localparam logic [17:0] VAlu0    = 18'h04000;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (act_vec !== e.vec || retired !== e.ret) begin
        failures++;
        $display("FAIL %s: got ctl=%05h retired=%04h, want ctl=%05h retired=%04h",
                 e.name, act_vec, retired, e.vec, e.ret);
      end
    end
  end

  task automatic drive(input logic [4:0] op, input logic r, input logic z, input logic c,
                       input logic st, input logic rs);
    opcodeFunc = op; rst = r; Zout = z; Cout = c; step = st; resume = rs;
  endtask

  task automatic expect_out(input string name, input logic [17:0] vec, input logic [15:0] ret);
    exp_t e;
    e.name = name; e.vec = vec; e.ret = ret;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    expect_out("reset", VReset, 16'd0);
    next_cycle();

    drive(5'b01010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("imm_alu", VImm2, 16'd0);
    next_cycle();
    drive(5'b10110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("bz_z0", VBrOff, 16'd1);
    next_cycle();
    drive(5'b10110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); expect_out("bz_z1", VBrOn, 16'd2);
    next_cycle();

    drive(5'b11101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("halt_exec", VHold, 16'd3);
    next_cycle();
    drive(5'b10101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("halted_idle", VHalted, 16'd3);
    next_cycle();
    drive(5'b10101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); expect_out("step_stm", VStmStep, 16'd3);
    next_cycle();
    drive(5'b10101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("after_step", VHalted, 16'd4);
    next_cycle();
    drive(5'b10101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); expect_out("step_resume", VHalted, 16'd4);
    next_cycle();
    drive(5'b10101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("resumed_run", VStmRun, 16'd4);
    next_cycle();
    drive(5'b11111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("illegal", VIllegal, 16'd5);
    next_cycle();

    for (int i = 0; i < 8; i++) begin
      drive(5'b11011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out($sformatf("jsb_%0d", i), VJsb, 16'(6 + i));
      next_cycle();
    end
    drive(5'b11011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("jsb_overflow", VHold, 16'd14);
    next_cycle();
    drive(5'b11011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); expect_out("fault_step", VFault, 16'd14);
    next_cycle();
    drive(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); expect_out("fault_resume", VFault, 16'd14);
    next_cycle();
    drive(5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); expect_out("rst_in_fault", VReset, 16'd14);
    next_cycle();

    drive(5'b01010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("run_after_rst", VImm2, 16'd0);
    next_cycle();
    drive(5'b11100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("ret_underflow", VHold, 16'd1);
    next_cycle();
    drive(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("fault_after_ret", VFault, 16'd1);
    next_cycle();
    drive(5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("rst2", VReset, 16'd1);
    next_cycle();

    drive(5'b11011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("jsb_ok", VJsb, 16'd0);
    next_cycle();
    drive(5'b11100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("ret_ok", VRet, 16'd1);
    next_cycle();
    drive(5'b11100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("ret_empty", VHold, 16'd2);
    next_cycle();
    drive(5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("rst3", VReset, 16'd2);
    next_cycle();

    drive(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65535; i++) next_cycle();
    expect_out("retired_ffff", VAlu0, 16'hFFFF);
    next_cycle();
    expect_out("retired_wrap", VAlu0, 16'h0000);
    next_cycle();

    for (int i = 0; i < 5 && sb.size() > 0; i++) next_cycle();
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 8, return-stack capacity in entries.
REQ-002 SHALL have port clk, input, 1, the single clock; every state element updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port opcodeFunc, input, 5, decoded opcode/function field of the current instruction.
REQ-005 SHALL have ports Cout and Zout, input, 1 each, registered carry and zero flags.
REQ-006 SHALL have ports step and resume, input, 1 each, single-cycle debug pulses.
REQ-007 SHALL have ports push, pop, memWriteEn, regWriteEn, immAndmem, stm, ldm, branch, jmp and jsb, output, 1 each, datapath controls; jsb=1 selects stack read data as the next PC.
REQ-008 SHALL have port aluOp, output, 4, ALU operation select.
REQ-009 SHALL have port pcHold, output, 1; 1 freezes the PC for the cycle.
REQ-010 SHALL have ports halted, fault and illegal, output, 1 each, status.
REQ-011 SHALL have port retired, output, 16, count of executed instructions.

Function
REQ-012 SHALL decode opcodes 00000-00111 as register ALU ops: regWriteEn=1, immAndmem=0, aluOp={0,opcodeFunc[2:0]}.
REQ-013 SHALL decode 01000-01111 as immediate ALU ops: regWriteEn=1, immAndmem=1, aluOp={0,opcodeFunc[2:0]}.
REQ-014 SHALL decode 10000-10011 as shift/rotate ops: regWriteEn=1, aluOp={10,opcodeFunc[1:0]}.
REQ-015 SHALL decode 10100 LDM as immAndmem=1, ldm=1, regWriteEn=1, aluOp=0000, and 10101 STM as immAndmem=1, stm=1, memWriteEn=1, aluOp=0000.
REQ-016 SHALL decode 10110 BZ, 10111 BNZ, 11000 BC and 11001 BNC with branch = Zout, ~Zout, Cout and ~Cout respectively.
REQ-017 SHALL decode 11010 JMP as jmp=1, 11011 JSB as jmp=1 with push=1, and 11100 RET as pop=1 with jsb=1.
REQ-018 SHALL decode 11101 as HALT; 11110 and 11111 SHALL act as NOP with illegal=1 for that cycle.
REQ-019 SHALL drive every unlisted control to 0 and aluOp to 0000.
REQ-020 SHALL implement run-control FSM states RUN, HALTED and FAULT.
REQ-021 In RUN, SHALL execute one instruction per cycle with pcHold=0, except as stated below.
REQ-022 On HALT in RUN, SHALL drive pcHold=1 with all enables 0 and enter HALTED next cycle.
REQ-023 In HALTED, SHALL drive pcHold=1 and all of push, pop, memWriteEn, regWriteEn, branch, jmp and jsb to 0.
REQ-024 In HALTED, resume SHALL enter RUN next cycle; resume SHALL win when step and resume are both 1.
REQ-025 In HALTED, step alone SHALL execute exactly one instruction that cycle (normal decode, pcHold=0) and remain HALTED; a HALT executed by step SHALL leave the PC held.
REQ-026 SHALL keep a stack depth counter of 0..STACK_DEPTH: +1 per executed JSB, -1 per executed RET.
REQ-027 A JSB at depth STACK_DEPTH, or a RET at depth 0, SHALL suppress all enables, drive pcHold=1 and enter FAULT; depth SHALL stay unchanged.
REQ-028 FAULT SHALL behave as HALTED, ignore step and resume, and exit only on rst.
REQ-029 SHALL increment retired once per cycle in which an instruction executes (pcHold=0, HALT excluded), wrapping from FFFF to 0000.
REQ-030 SHALL drive halted=1 in HALTED and fault=1 in FAULT.

Reset
REQ-031 When rst is asserted, the next state SHALL be RUN, with depth=0 and retired=0.
REQ-032 While rst=1, all controls SHALL be 0, pcHold SHALL be 1, and halted, fault and illegal SHALL be 0.
REQ-033 rst SHALL override any operation in progress, including a pending step or a FAULT.

Structure
REQ-034 Opcode constants, aluOp codes, FSM state encoding and STACK_DEPTH default SHALL be placed in shared package cpu_pkg.
REQ-035 The combinational opcode decode SHALL be placed in one sub-module, ctrl_decoder; the FSM, depth counter and retired counter SHALL reside in cpu_controller.

Verification
REQ-036 The bench SHALL check: opcodeFunc=01010 in RUN -> regWriteEn=1, immAndmem=1, aluOp=0010, pcHold=0, and retired increments by 1.
REQ-037 The bench SHALL check: BZ with Zout=0 -> branch=0; BZ with Zout=1 -> branch=1.
REQ-038 The bench SHALL check: 8 executed JSBs -> depth 8; a 9th JSB -> push=0, pcHold=1, fault=1 next cycle; step and resume ignored; rst -> RUN with depth 0.
REQ-039 The bench SHALL check: RET at depth 0 -> pop=0, FAULT entered.
REQ-040 The bench SHALL check: HALT -> halted=1; step with opcodeFunc=10101 -> memWriteEn=1 for one cycle only, still halted; step=1 and resume=1 together -> RUN.
REQ-041 The bench SHALL check: retired preloaded to FFFF via 65535 NOPs, then one more NOP -> retired=0000; opcodeFunc=11111 -> illegal=1 with all enables 0.
